gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 90 +++++++++
 tb/tb_gray_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output and valid/ready handshake.
// Optional Gray-adjacency error monitor: define GRAY_ADJ_CHECK_EN.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAX  = '1;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // A presented value must be consumed before the count may move on.
    assign adv = en && (!out_valid || out_ready);

    always_comb begin
        bin_next  = bin_out;
        wrap_next = 1'b0;
        if (up_dn) begin
            bin_next  = bin_out + ONE;
            wrap_next = (bin_out == MAX);
        end else begin
            bin_next  = bin_out - ONE;
            wrap_next = (bin_out == ZERO);
        end
    end

    assign gray_next = to_gray(bin_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out   <= '0;
            gray_out  <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (load) begin
            bin_out   <= load_val;
            gray_out  <= to_gray(load_val);
            out_valid <= 1'b1;
            wrap      <= 1'b0;
        end else if (adv) begin
            bin_out   <= bin_next;
            gray_out  <= gray_next;
            out_valid <= 1'b1;
            wrap      <= wrap_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] gray_diff;
    logic             one_hot;

    // Exactly one bit may change between consecutive counted Gray values.
    assign gray_diff = gray_next ^ gray_out;
    assign one_hot   = (gray_diff != ZERO) && ((gray_diff & (gray_diff - ONE)) == ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!load && adv && !one_hot) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (WIDTH = 4).
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       out_valid;
    logic       out_ready;
    logic       wrap;
    logic       err;

    int passes = 0;
    int total  = 0;

    logic [3:0] gray_tab [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                  4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000};

    gray_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] b, input logic [3:0] g,
                           input logic v, input logic w);
        chk({tag, ".bin"}, bin_out, b);
        chk({tag, ".gray"}, gray_out, g);
        chk({tag, ".valid"}, {3'b0, out_valid}, {3'b0, v});
        chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = 4'h0; out_ready = 1'b1;
        #12;
        chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("reset.err", {3'b0, err}, 4'h0);

        // full up-count lap with wrap on the 15 -> 0 step
        step();
        rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk_all($sformatf("up%0d", i), 4'((i + 1) % 16), gray_tab[i], 1'b1, (i == 15));
        end

        // stalled value keeps its wrap flag
        out_ready = 1'b0;
        step();
        chk_all("wrap_hold", 4'h0, 4'h0, 1'b1, 1'b1);

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0);
        step();

        // down step from reset wraps to max
        rst_n = 1'b1; up_dn = 1'b0; out_ready = 1'b1; en = 1'b1;
        step();
        chk_all("down_wrap", 4'hF, 4'b1000, 1'b1, 1'b1);
        step();
        chk_all("down_next", 4'hE, 4'b1001, 1'b1, 1'b0);

        // stall at 5 for five cycles, then resume
        load = 1'b1; load_val = 4'h5;
        step();
        chk_all("load5", 4'h5, 4'b0111, 1'b1, 1'b0);
        load = 1'b0; up_dn = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("stall%0d", i), 4'h5, 4'b0111, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk_all("resume", 4'h6, 4'b0101, 1'b1, 1'b0);

        // load wins over en even when the consumer is stalled
        out_ready = 1'b0; load = 1'b1; load_val = 4'hA; en = 1'b1;
        step();
        chk_all("load10", 4'hA, 4'b1111, 1'b1, 1'b0);
        chk("load10.err", {3'b0, err}, 4'h0);

        // drain: valid drops, data holds
        load = 1'b0; en = 1'b0; out_ready = 1'b1;
        step();
        chk_all("drain", 4'hA, 4'b1111, 1'b0, 1'b0);
        out_ready = 1'b0;
        step();
        chk_all("idle", 4'hA, 4'b1111, 1'b0, 1'b0);

        // reset during a stall discards the pending value
        load = 1'b1; load_val = 4'h3;
        step();
        load = 1'b0; en = 1'b1; out_ready = 1'b0;
        step();
        chk_all("prestall", 4'h3, 4'b0010, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("stall_rst", 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk_all("post_rst", 4'h1, 4'b0001, 1'b1, 1'b0);

`ifdef GRAY_ADJ_CHECK_EN
        chk("err_clean", {3'b0, err}, 4'h0);
        en = 1'b0;
        step();
        force dut.bin_out = 4'hA;
        #1;
        release dut.bin_out;
        en = 1'b1;
        step();
        chk("err_set", {3'b0, err}, 4'h1);
        step();
        step();
        chk("err_sticky", {3'b0, err}, 4'h1);
`else
        step();
        chk("err_tied", {3'b0, err}, 4'h0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
